// File: rtl/car_pkg.sv
// Shared constants, fixed-point widths, FSM states and heading helper for the car motion engine.
// Pure definitions; no timing or flow control of its own.
package car_pkg;

  localparam int HEADING_STEPS = 24;
  localparam int DEG_PER_STEP  = 15;
  localparam int HEAD_W        = 5;

  localparam int POS_FRAC = 4;
  localparam int POS_W    = 14;
  localparam int SPEED_W  = 7;
  localparam int TRIG_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    STEER,
    MOVE,
    PROBE,
    WAIT,
    COMMIT
  } car_state_t;

  typedef logic [HEAD_W-1:0] heading_t;

  // ccw decrements, cw increments, both or neither hold; wraps 0 <-> 23.
  function automatic heading_t heading_step(input heading_t h, input logic ccw, input logic cw);
    heading_t r;
    r = h;
    if (ccw && !cw)
      r = (h == '0) ? HEAD_W'(HEADING_STEPS - 1) : h - HEAD_W'(1);
    else if (cw && !ccw)
      r = (h == HEAD_W'(HEADING_STEPS - 1)) ? '0 : h + HEAD_W'(1);
    return r;
  endfunction

endpackage

// File: rtl/car_kinematics_trig_lut.sv
// Combinational 24-entry sin/cos table (signed Q1.7, +/-127) in 15-degree steps, heading 0 = north.
// Zero latency, no backpressure.
module trig_lut
  import car_pkg::*;
(
  input  logic [HEAD_W-1:0]        heading,
  output logic signed [TRIG_W-1:0] sin_q,
  output logic signed [TRIG_W-1:0] cos_q
);

  function automatic logic signed [TRIG_W-1:0] sin_entry(input logic [HEAD_W-1:0] h);
    case (h)
      5'd0:    return  8'sd0;
      5'd1:    return  8'sd33;
      5'd2:    return  8'sd64;
      5'd3:    return  8'sd90;
      5'd4:    return  8'sd110;
      5'd5:    return  8'sd123;
      5'd6:    return  8'sd127;
      5'd7:    return  8'sd123;
      5'd8:    return  8'sd110;
      5'd9:    return  8'sd90;
      5'd10:   return  8'sd64;
      5'd11:   return  8'sd33;
      5'd12:   return  8'sd0;
      5'd13:   return -8'sd33;
      5'd14:   return -8'sd64;
      5'd15:   return -8'sd90;
      5'd16:   return -8'sd110;
      5'd17:   return -8'sd123;
      5'd18:   return -8'sd127;
      5'd19:   return -8'sd123;
      5'd20:   return -8'sd110;
      5'd21:   return -8'sd90;
      5'd22:   return -8'sd64;
      5'd23:   return -8'sd33;
      default: return  8'sd0;
    endcase
  endfunction

  logic [HEAD_W-1:0] cos_idx;

  // cos(h) = sin(h + 90 deg), i.e. six steps ahead modulo 24.
  always_comb begin
    cos_idx = (heading >= HEAD_W'(HEADING_STEPS - 6)) ? heading - HEAD_W'(HEADING_STEPS - 6)
                                                       : heading + HEAD_W'(6);
    sin_q   = sin_entry(heading);
    cos_q   = sin_entry(cos_idx);
  end

endmodule

// File: rtl/car_kinematics.sv
// Per-player motion engine: steer, move, probe terrain, commit once per frame_tick; 5 cycles tick->update_done.
// No backpressure: frame_tick is accepted only in IDLE, ticks arriving mid-sequence are dropped.
module car_kinematics
  import car_pkg::*;
#(
  parameter int         START_X       = 40,
  parameter int         START_Y       = 40,
  parameter int         START_HEADING = 0,
  parameter int         MAX_SPEED     = 16,
  parameter int         ACCEL         = 1,
  parameter int         FRICTION      = 1,
  parameter int         MAP_WIDTH     = 320,
  parameter int         MAP_HEIGHT    = 240,
  parameter logic [3:0] BLOCK_INDEX   = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        btn_gas,
  input  logic        btn_brake,
  input  logic        btn_left,
  input  logic        btn_right,
  output logic [16:0] map_addr,
  input  logic [3:0]  map_data,
  output logic [9:0]  world_x,
  output logic [9:0]  world_y,
  output logic [8:0]  degree,
  output logic        update_done
);

  localparam int SW1    = SPEED_W + 1;
  localparam int PROD_W = SPEED_W + TRIG_W;
  localparam int INT_W  = POS_W - POS_FRAC;

  localparam logic [POS_W-1:0]    RST_POS_X = POS_W'(START_X * (1 << POS_FRAC));
  localparam logic [POS_W-1:0]    RST_POS_Y = POS_W'(START_Y * (1 << POS_FRAC));
  localparam heading_t            RST_HEAD  = HEAD_W'(START_HEADING);
  localparam logic [8:0]          RST_DEG   = 9'(START_HEADING * DEG_PER_STEP);
  localparam logic signed [SW1-1:0] SPD_HI   = SW1'(MAX_SPEED);
  localparam logic signed [SW1-1:0] SPD_LO   = SW1'(-(MAX_SPEED / 2));
  localparam logic signed [SW1-1:0] SPD_ACC  = SW1'(ACCEL);
  localparam logic signed [SW1-1:0] SPD_FRC  = SW1'(FRICTION);
  localparam logic signed [SW1-1:0] SPD_NFRC = SW1'(-FRICTION);
  localparam logic [16:0]         MAP_W17   = 17'(MAP_WIDTH);

  car_state_t                 state;
  logic [POS_W-1:0]           pos_x, pos_y;
  heading_t                   heading;
  logic signed [SPEED_W-1:0]  speed;
  logic signed [POS_W:0]      cand_x, cand_y;
  logic                       rejected;

  logic signed [TRIG_W-1:0]   sin_q, cos_q, neg_cos;
  logic signed [PROD_W-1:0]   prod_x, prod_y;
  logic signed [POS_W:0]      dx, dy, pos_sx, pos_sy;
  logic signed [SW1-1:0]      spd_ext, spd_sum;
  logic signed [SPEED_W-1:0]  speed_nxt;
  logic [INT_W-1:0]           cx_int, cy_int;
  logic                       oob;

  trig_lut u_trig (
    .heading (heading),
    .sin_q   (sin_q),
    .cos_q   (cos_q)
  );

  always_comb begin
    spd_ext   = {speed[SPEED_W-1], speed};
    spd_sum   = spd_ext;
    speed_nxt = speed;
    case ({btn_gas, btn_brake})
      2'b10: begin
        spd_sum   = spd_ext + SPD_ACC;
        speed_nxt = (spd_sum > SPD_HI) ? SPD_HI[SPEED_W-1:0] : spd_sum[SPEED_W-1:0];
      end
      2'b01: begin
        spd_sum   = spd_ext - SPD_ACC;
        speed_nxt = (spd_sum < SPD_LO) ? SPD_LO[SPEED_W-1:0] : spd_sum[SPEED_W-1:0];
      end
      default: begin
        // Coasting decays toward zero and snaps to zero inside the friction band.
        if (spd_ext > SPD_FRC)
          spd_sum = spd_ext - SPD_FRC;
        else if (spd_ext < SPD_NFRC)
          spd_sum = spd_ext + SPD_FRC;
        else
          spd_sum = '0;
        speed_nxt = spd_sum[SPEED_W-1:0];
      end
    endcase
  end

  // Screen y grows downward, so forward motion uses -cos; both axes floor after the Q1.7 product.
  always_comb begin
    neg_cos = -cos_q;
    prod_x  = PROD_W'(speed) * PROD_W'(sin_q);
    prod_y  = PROD_W'(speed) * PROD_W'(neg_cos);
    dx      = prod_x >>> (TRIG_W - 1);
    dy      = prod_y >>> (TRIG_W - 1);
    pos_sx  = {1'b0, pos_x};
    pos_sy  = {1'b0, pos_y};
  end

  assign cx_int = cand_x[POS_W-1:POS_FRAC];
  assign cy_int = cand_y[POS_W-1:POS_FRAC];
  assign oob    = cand_x[POS_W] | cand_y[POS_W] |
                  (cx_int >= INT_W'(MAP_WIDTH)) | (cy_int >= INT_W'(MAP_HEIGHT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pos_x       <= RST_POS_X;
      pos_y       <= RST_POS_Y;
      heading     <= RST_HEAD;
      speed       <= '0;
      cand_x      <= '0;
      cand_y      <= '0;
      rejected    <= 1'b0;
      map_addr    <= '0;
      update_done <= 1'b0;
      world_x     <= 10'(START_X);
      world_y     <= 10'(START_Y);
      degree      <= RST_DEG;
    end else begin
      update_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (frame_tick) begin
            rejected <= 1'b0;
            state    <= STEER;
          end
        end
        STEER: begin
          heading <= heading_step(heading, btn_left, btn_right);
          speed   <= speed_nxt;
          state   <= MOVE;
        end
        MOVE: begin
          cand_x <= pos_sx + dx;
          cand_y <= pos_sy + dy;
          state  <= PROBE;
        end
        PROBE: begin
          if (oob)
            rejected <= 1'b1;
          else
            map_addr <= {7'd0, cy_int} * MAP_W17 + {7'd0, cx_int};
          state <= WAIT;
        end
        WAIT: begin
          if (map_data == BLOCK_INDEX)
            rejected <= 1'b1;
          state <= COMMIT;
        end
        COMMIT: begin
          if (rejected) begin
            speed   <= '0;
            world_x <= pos_x[POS_W-1:POS_FRAC];
            world_y <= pos_y[POS_W-1:POS_FRAC];
          end else begin
            pos_x   <= cand_x[POS_W-1:0];
            pos_y   <= cand_y[POS_W-1:0];
            world_x <= cx_int;
            world_y <= cy_int;
          end
          degree      <= 9'(heading) * 9'(DEG_PER_STEP);
          update_done <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
